max7219_chain_checker: RTL and testbench

- Testbench-side passive monitor for a MAX7219 serial interface driving a daisy chain of G_NB_DEVICES devices.
- Shifts DIN on each MAX7219 CLK rising edge while LOAD is low, and delivers the whole chain frame on the LOAD rising edge, which is the MAX7219 latch point.
- Checks frame length and protocol violations and keeps a frame counter.
- Optionally mirrors each device's register file so the bench can check displayed content.

---
 rtl/max7219_chain_checker_pkg.sv | 31 +++
 rtl/max7219_chain_checker_if.sv | 9 +
 rtl/max7219_chain_checker_shadow_regs.sv | 21 ++
 rtl/max7219_chain_checker.sv | 136 +++++++++++++
 tb/tb_max7219_chain_checker.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max7219_chain_checker_pkg.sv
// Shared constants and types for the MAX7219 chain checker.
// The optional register mirror is enabled with MAX7219_CHECKER_SHADOW_EN.
package max7219_checker_pkg;

    localparam int C_WORD_WIDTH = 16;

    localparam logic [3:0] C_ADDR_NOOP         = 4'h0;
    localparam logic [3:0] C_ADDR_DIGIT0       = 4'h1;
    localparam logic [3:0] C_ADDR_DIGIT1       = 4'h2;
    localparam logic [3:0] C_ADDR_DIGIT2       = 4'h3;
    localparam logic [3:0] C_ADDR_DIGIT3       = 4'h4;
    localparam logic [3:0] C_ADDR_DIGIT4       = 4'h5;
    localparam logic [3:0] C_ADDR_DIGIT5       = 4'h6;
    localparam logic [3:0] C_ADDR_DIGIT6       = 4'h7;
    localparam logic [3:0] C_ADDR_DIGIT7       = 4'h8;
    localparam logic [3:0] C_ADDR_DECODE       = 4'h9;
    localparam logic [3:0] C_ADDR_INTENSITY    = 4'hA;
    localparam logic [3:0] C_ADDR_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] C_ADDR_SHUTDOWN     = 4'hC;
    localparam logic [3:0] C_ADDR_DISPLAY_TEST = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } t_chk_state;

    function automatic int frame_width(input int nb_devices);
        return C_WORD_WIDTH * nb_devices;
    endfunction

endpackage

// File: rtl/max7219_chain_checker_if.sv
// MAX7219 serial bus as seen by the checker: the driver owns it, the checker only listens.
interface max7219_chain_checker_if;
    logic max7219_clk;
    logic max7219_din;
    logic max7219_load;

    modport master (output max7219_clk, output max7219_din, output max7219_load);
    modport slave  (input  max7219_clk, input  max7219_din, input  max7219_load);
endinterface

// File: rtl/max7219_chain_checker_shadow_regs.sv
// One MAX7219 register file mirror: 16 x 8 bits, single write port.
module max7219_shadow_regs
    import max7219_checker_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [3:0]   addr,
    input  logic [7:0]   data,
    output logic [127:0] regs
);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (we) begin
            regs[addr*8 +: 8] <= data;
        end
    end

endmodule

// File: rtl/max7219_chain_checker.sv
// Passive MAX7219 daisy-chain monitor: frame capture, length/protocol checks, frame counter.
// Define MAX7219_CHECKER_SHADOW_EN to mirror every device's register file on o_shadow.
module max7219_chain_checker
    import max7219_checker_pkg::*;
#(
    parameter int G_NB_DEVICES  = 1,
    parameter int G_FRAME_CNT_W = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    max7219_chain_checker_if.slave                  bus,
    input  logic                                    i_clr_err,
    output logic                                    o_frame_valid,
    output logic [16*G_NB_DEVICES-1:0]              o_frame_data,
    output logic [$clog2(16*G_NB_DEVICES+2)-1:0]    o_bit_cnt,
    output logic                                    o_err_length,
    output logic                                    o_err_protocol,
    output logic [G_FRAME_CNT_W-1:0]                o_frame_cnt,
    output logic [G_NB_DEVICES*128-1:0]             o_shadow
);

    localparam int C_FRAME_W = frame_width(G_NB_DEVICES);
    localparam int C_CNT_W   = $clog2(C_FRAME_W + 2);
    localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(C_FRAME_W);
    localparam logic [C_CNT_W-1:0] C_CNT_SAT  = C_CNT_W'(C_FRAME_W + 1);

    t_chk_state             state;
    logic                   clk_s;
    logic                   load_s;
    logic [C_FRAME_W-1:0]   shreg;
    logic [C_FRAME_W-1:0]   shreg_nxt;
    logic [C_CNT_W-1:0]     cnt_nxt;
    logic                   clk_rise;
    logic                   load_fall;
    logic                   load_rise;
    logic                   start;
    logic                   latch;
    logic                   prot_err;

    assign clk_rise  = bus.max7219_clk & ~clk_s;
    assign load_fall = ~bus.max7219_load & load_s;
    assign load_rise = bus.max7219_load & ~load_s;
    assign latch     = (state == SHIFT) & load_rise;

    // A clk edge coinciding with a LOAD edge is shifted before the latch / counted at frame start.
    always_comb begin
        shreg_nxt = shreg;
        cnt_nxt   = o_bit_cnt;
        start     = 1'b0;
        prot_err  = 1'b0;
        case (state)
            IDLE: begin
                if (load_fall) begin
                    start   = 1'b1;
                    cnt_nxt = '0;
                    if (clk_rise) begin
                        shreg_nxt = {shreg[C_FRAME_W-2:0], bus.max7219_din};
                        cnt_nxt   = C_CNT_W'(1);
                    end
                end else if (clk_rise) begin
                    prot_err = 1'b1;
                end
            end
            SHIFT: begin
                if (clk_rise) begin
                    shreg_nxt = {shreg[C_FRAME_W-2:0], bus.max7219_din};
                    cnt_nxt   = (o_bit_cnt == C_CNT_SAT) ? o_bit_cnt : o_bit_cnt + C_CNT_W'(1);
                end
            end
            default: begin
                shreg_nxt = shreg;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            clk_s          <= 1'b0;
            load_s         <= 1'b1;
            shreg          <= '0;
            o_bit_cnt      <= '0;
            o_frame_valid  <= 1'b0;
            o_frame_data   <= '0;
            o_frame_cnt    <= '0;
            o_err_length   <= 1'b0;
            o_err_protocol <= 1'b0;
        end else begin
            clk_s         <= bus.max7219_clk;
            load_s        <= bus.max7219_load;
            shreg         <= shreg_nxt;
            o_bit_cnt     <= cnt_nxt;
            o_frame_valid <= latch;
            if (start) begin
                state <= SHIFT;
            end else if (latch) begin
                state <= IDLE;
            end
            if (latch) begin
                o_frame_data <= shreg_nxt;
                if (cnt_nxt == C_CNT_FULL) begin
                    o_frame_cnt <= o_frame_cnt + G_FRAME_CNT_W'(1);
                end
            end
            // A new error in the clearing cycle must survive the clear.
            o_err_length   <= (o_err_length & ~i_clr_err) | (latch & (cnt_nxt != C_CNT_FULL));
            o_err_protocol <= (o_err_protocol & ~i_clr_err) | prot_err;
        end
    end

`ifdef MAX7219_CHECKER_SHADOW_EN
    logic frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ok <= 1'b0;
        end else begin
            frame_ok <= latch & (cnt_nxt == C_CNT_FULL);
        end
    end

    for (genvar d = 0; d < G_NB_DEVICES; d++) begin : g_dev
        max7219_shadow_regs u_regs (
            .clk  (clk),
            .rst  (rst),
            .we   (frame_ok && (o_frame_data[d*16+8 +: 4] != C_ADDR_NOOP)),
            .addr (o_frame_data[d*16+8 +: 4]),
            .data (o_frame_data[d*16 +: 8]),
            .regs (o_shadow[d*128 +: 128])
        );
    end
`else
    assign o_shadow = '0;
`endif

endmodule

// File: tb/tb_max7219_chain_checker.sv
// Bench for max7219_chain_checker: a 1-device and a 2-device (2-bit frame counter) checker share one bus.
module tb_max7219_chain_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_err = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    max7219_chain_checker_if bus ();

    logic         v1, v2;
    logic [15:0]  d1;
    logic [31:0]  d2;
    logic [4:0]   c1;
    logic [5:0]   c2;
    logic         el1, el2, ep1, ep2;
    logic [15:0]  f1;
    logic [1:0]   f2;
    logic [127:0] s1;
    logic [255:0] s2;

    max7219_chain_checker #(.G_NB_DEVICES(1), .G_FRAME_CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus), .i_clr_err(clr_err),
        .o_frame_valid(v1), .o_frame_data(d1), .o_bit_cnt(c1), .o_err_length(el1),
        .o_err_protocol(ep1), .o_frame_cnt(f1), .o_shadow(s1));

    max7219_chain_checker #(.G_NB_DEVICES(2), .G_FRAME_CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus), .i_clr_err(clr_err),
        .o_frame_valid(v2), .o_frame_data(d2), .o_bit_cnt(c2), .o_err_length(el2),
        .o_err_protocol(ep2), .o_frame_cnt(f2), .o_shadow(s2));

    // Reference model: k=0 is the 1-device checker, k=1 the 2-device checker.
    logic [63:0] m_sh [2];
    logic [63:0] m_data [2];
    int          m_cnt [2];
    logic        m_el [2];
    logic        m_ep [2];
    int          m_fcnt [2];
    logic [7:0]  m_shadow [2][2][16];

    typedef struct {
        logic [31:0] val;
        int          n;
        logic [15:0] data;
        logic [4:0]  cnt;
        logic        err_len;
        logic [15:0] fcnt;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sh[k] = '0; m_data[k] = '0; m_cnt[k] = 0;
            m_el[k] = 1'b0; m_ep[k] = 1'b0; m_fcnt[k] = 0;
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 16; a++) m_shadow[k][d][a] = 8'h00;
        end
    endtask

    task automatic do_reset();
        bus.max7219_clk = 1'b0;
        bus.max7219_din = 1'b0;
        bus.max7219_load = 1'b1;
        clr_err = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic model_frame(input logic [63:0] val, input int n);
        for (int k = 0; k < 2; k++) begin
            int fw;
            logic [63:0] mask;
            fw = 16 * (k + 1);
            mask = (64'd1 << fw) - 64'd1;
            for (int i = n - 1; i >= 0; i--) m_sh[k] = ((m_sh[k] << 1) | 64'(val[i])) & mask;
            m_cnt[k] = (n > fw + 1) ? fw + 1 : n;
            m_data[k] = m_sh[k];
            if (n == fw) begin
                m_fcnt[k] = (m_fcnt[k] + 1) % ((k == 0) ? 65536 : 4);
`ifdef MAX7219_CHECKER_SHADOW_EN
                for (int d = 0; d <= k; d++) begin
                    logic [15:0] w;
                    w = m_data[k][d*16 +: 16];
                    if (w[11:8] != 4'h0) m_shadow[k][d][w[11:8]] = w[7:0];
                end
`endif
            end else begin
                m_el[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [255:0] shadow_vec(input int k);
        logic [255:0] v;
        v = '0;
        for (int d = 0; d <= k; d++)
            for (int a = 0; a < 16; a++) v[d*128 + a*8 +: 8] = m_shadow[k][d][a];
        return v;
    endfunction

    task automatic send_bit(input logic b);
        bus.max7219_din = b;
        bus.max7219_clk = 1'b1;
        tick();
        bus.max7219_clk = 1'b0;
        tick();
    endtask

    // Ends one cycle after the LOAD rise is sampled, i.e. in the frame_valid cycle.
    task automatic send_frame(input logic [63:0] val, input int n);
        bus.max7219_load = 1'b0;
        tick();
        for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
        bus.max7219_load = 1'b1;
        tick();
    endtask

    task automatic prot_pulse();
        bus.max7219_clk = 1'b1;
        tick();
        bus.max7219_clk = 1'b0;
        tick();
        m_ep[0] = 1'b1; m_ep[1] = 1'b1;
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        for (int k = 0; k < 2; k++) begin m_el[k] = 1'b0; m_ep[k] = 1'b0; end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid1"}, 256'(v1), 256'(1));
        chk({tag, " valid2"}, 256'(v2), 256'(1));
        chk({tag, " data1"}, 256'(d1), 256'(m_data[0]));
        chk({tag, " data2"}, 256'(d2), 256'(m_data[1]));
        chk({tag, " cnt1"}, 256'(c1), 256'(m_cnt[0]));
        chk({tag, " cnt2"}, 256'(c2), 256'(m_cnt[1]));
        chk({tag, " errlen1"}, 256'(el1), 256'(m_el[0]));
        chk({tag, " errlen2"}, 256'(el2), 256'(m_el[1]));
        chk({tag, " errprot1"}, 256'(ep1), 256'(m_ep[0]));
        chk({tag, " errprot2"}, 256'(ep2), 256'(m_ep[1]));
        chk({tag, " fcnt1"}, 256'(f1), 256'(m_fcnt[0]));
        chk({tag, " fcnt2"}, 256'(f2), 256'(m_fcnt[1]));
        tick();
        chk({tag, " pulse end1"}, 256'(v1), 256'(0));
        chk({tag, " pulse end2"}, 256'(v2), 256'(0));
        chk({tag, " shadow1"}, 256'(s1), shadow_vec(0));
        chk({tag, " shadow2"}, s2, shadow_vec(1));
    endtask

    initial begin
        logic [63:0] rv;
        int          n;
        logic [15:0] cv;
        logic [1:0]  wrap_exp [5];

        tbl[0] = '{32'h0000_0C01, 16, 16'h0C01, 5'd16, 1'b0, 16'd1};
        tbl[1] = '{32'h0000_0A05, 16, 16'h0A05, 5'd16, 1'b0, 16'd2};
        tbl[2] = '{32'h0000_1234, 15, 16'h9234, 5'd15, 1'b1, 16'd2};
        tbl[3] = '{32'h0001_ABCD, 17, 16'hABCD, 5'd17, 1'b1, 16'd2};
        tbl[4] = '{32'h0000_0000,  0, 16'hABCD, 5'd0,  1'b1, 16'd2};
        tbl[5] = '{32'h000F_0123, 20, 16'h0123, 5'd17, 1'b1, 16'd2};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset();
        chk("reset data1", 256'(d1), 256'(0));
        chk("reset cnt1", 256'(c1), 256'(0));
        chk("reset fcnt1", 256'(f1), 256'(0));
        chk("reset errs1", 256'({el1, ep1, v1}), 256'(0));
        chk("reset shadow2", s2, 256'(0));

        for (int i = 0; i < 6; i++) begin
            send_frame(64'(tbl[i].val), tbl[i].n);
            chk($sformatf("tbl%0d valid", i), 256'(v1), 256'(1));
            chk($sformatf("tbl%0d data", i), 256'(d1), 256'(tbl[i].data));
            chk($sformatf("tbl%0d bitcnt", i), 256'(c1), 256'(tbl[i].cnt));
            chk($sformatf("tbl%0d errlen", i), 256'(el1), 256'(tbl[i].err_len));
            chk($sformatf("tbl%0d fcnt", i), 256'(f1), 256'(tbl[i].fcnt));
            tick();
            chk($sformatf("tbl%0d pulse end", i), 256'(v1), 256'(0));
        end
`ifdef MAX7219_CHECKER_SHADOW_EN
        chk("shadow1 shutdown", 256'(s1[8'hC*8 +: 8]), 256'(8'h01));
        chk("shadow1 intensity", 256'(s1[8'hA*8 +: 8]), 256'(8'h05));
`else
        chk("shadow1 tied off", 256'(s1), 256'(0));
`endif

        prot_pulse();
        chk("prot set", 256'(ep1), 256'(1));
        clr_err = 1'b1;
        bus.max7219_clk = 1'b1;
        tick();
        clr_err = 1'b0;
        bus.max7219_clk = 1'b0;
        tick();
        chk("prot set beats clr", 256'(ep1), 256'(1));
        chk("errlen cleared", 256'(el1), 256'(0));
        clear_errors();
        chk("prot cleared", 256'(ep1), 256'(0));

        // LOAD fall with a clk edge starts the frame; last clk edge with LOAD rise is included.
        do_reset();
        cv = 16'hB6C3;
        bus.max7219_load = 1'b0;
        bus.max7219_din = cv[15];
        bus.max7219_clk = 1'b1;
        tick();
        bus.max7219_clk = 1'b0;
        tick();
        for (int i = 14; i >= 1; i--) send_bit(cv[i]);
        bus.max7219_din = cv[0];
        bus.max7219_clk = 1'b1;
        bus.max7219_load = 1'b1;
        tick();
        bus.max7219_clk = 1'b0;
        chk("corner valid", 256'(v1), 256'(1));
        chk("corner data", 256'(d1), 256'(16'hB6C3));
        chk("corner bitcnt", 256'(c1), 256'(16));
        chk("corner fcnt", 256'(f1), 256'(1));
        chk("corner errs", 256'({el1, ep1}), 256'(0));
        tick();

        do_reset();
        send_frame(64'h0A05_0103, 32);
        chk("dev2 data", 256'(d2), 256'(32'h0A05_0103));
        chk("dev2 bitcnt", 256'(c2), 256'(32));
        chk("dev2 fcnt", 256'(f2), 256'(1));
        chk("dev2 errlen", 256'(el2), 256'(0));
        tick();
        tick();
`ifdef MAX7219_CHECKER_SHADOW_EN
        chk("dev2 d0 digit0", 256'(s2[1*8 +: 8]), 256'(8'h03));
        chk("dev2 d0 intensity", 256'(s2[10*8 +: 8]), 256'(8'h00));
        chk("dev2 d1 intensity", 256'(s2[128 + 10*8 +: 8]), 256'(8'h05));
`else
        chk("dev2 shadow tied off", s2, 256'(0));
`endif

        // Reset in the middle of a frame.
        bus.max7219_load = 1'b0;
        tick();
        for (int i = 7; i >= 0; i--) send_bit(i[0]);
        rst = 1'b1;
        tick();
        bus.max7219_load = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("no valid after rst", 256'({v1, v2}), 256'(0));
            tick();
        end
        chk("rst outputs1", 256'({d1, c1, el1, ep1, f1}), 256'(0));
        chk("rst outputs2", 256'({d2, c2, el2, ep2, f2}), 256'(0));
        chk("rst shadow2", s2, 256'(0));
        send_frame(64'h0C01, 16);
        chk("post rst valid", 256'(v1), 256'(1));
        chk("post rst data", 256'(d1), 256'(16'h0C01));
        chk("post rst fcnt", 256'(f1), 256'(1));
        tick();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame(64'($urandom), 32);
            chk($sformatf("wrap fcnt %0d", i), 256'(f2), 256'(wrap_exp[i]));
            tick();
        end

        do_reset();
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: n = 16;
                1: n = 32;
                default: n = $urandom_range(0, 35);
            endcase
            rv = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) prot_pulse();
            if ($urandom_range(0, 5) == 0) clear_errors();
            send_frame(rv, n);
            model_frame(rv, n);
            check_model($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
